// File: rtl/score_digit_scanner_if.sv
// Signal bundle between the score digit scanner and its environment:
// score source, binary-to-decimal converter and HUD renderer read port.
interface score_digit_scanner_if #(
  parameter int WIDTH = 20
) ();
  // score source
  logic [WIDTH-1:0] score;
  logic             score_update;
  logic             busy;
  logic             scan_done;
  // converter
  logic [WIDTH-1:0] dec_number;
  logic [3:0]       dec_position;
  logic             dec_done;
  logic             dec_set;
  logic [4:0]       dec_digit;
  // renderer read port
  logic [2:0]       rd_sel;
  logic [3:0]       rd_digit;
  logic             rd_visible;

  // Environment side: score source, converter and renderer.
  modport master (
    output score, score_update, dec_done, dec_set, dec_digit, rd_sel,
    input  busy, scan_done, dec_number, dec_position, rd_digit, rd_visible
  );

  // Scanner side.
  modport slave (
    input  score, score_update, dec_done, dec_set, dec_digit, rd_sel,
    output busy, scan_done, dec_number, dec_position, rd_digit, rd_visible
  );
endinterface

// File: rtl/score_digit_scanner.sv
// Scans a binary score through a free-running binary-to-decimal converter one
// digit position at a time, filling a shadow digit bank, then swaps it into
// the display bank in a single cycle so the renderer never sees a torn score.
module score_digit_scanner #(
  parameter int NDIGITS       = 6,
  parameter int WIDTH         = 20,
  parameter int BLANK_LEADING = 1,
  parameter int TIMEOUT       = 64
) (
  input logic                  clk,
  input logic                  reset,
  score_digit_scanner_if.slave bus
);
  localparam int IW = $clog2(NDIGITS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIGITS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETPOS, DISCARD, CAPTURE, NEXT, SWAP} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic             pending;
  logic             busy_q;
  logic [WIDTH-1:0] number_q;
  logic [3:0]       position_q;
  logic [3:0]       rd_digit_q;
  logic             rd_visible_q;
  logic [3:0]       shadow [NDIGITS];
  logic [3:0]       disp   [NDIGITS];
  logic [NDIGITS-1:0] shadow_vis;
  logic [NDIGITS-1:0] disp_vis;

  // Control decoded from the current state.
  logic       start, set_pos, timer_run, wr_en, idx_inc, swap;
  logic [3:0] wr_digit;
  logic       wr_vis;
  logic       timeout_hit;
  logic       idx_zero;

  // Only the low nibble of the converter digit carries a decimal value.
  logic unused_digit_msb;
  assign unused_digit_msb = bus.dec_digit[4];

  assign timeout_hit = (timer == TIMER_MAX);
  assign idx_zero    = (idx == '0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_next = state;
    start      = 1'b0;
    set_pos    = 1'b0;
    timer_run  = 1'b0;
    wr_en      = 1'b0;
    wr_digit   = 4'd0;
    wr_vis     = 1'b0;
    idx_inc    = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.score_update || pending) begin
          start      = 1'b1;
          state_next = SETPOS;
        end
      end
      SETPOS: begin
        set_pos    = 1'b1;
        state_next = DISCARD;
      end
      DISCARD: begin
        // First dec_done after a position change may reflect stale inputs.
        timer_run = 1'b1;
        if (timeout_hit) begin
          wr_en      = 1'b1;
          wr_vis     = idx_zero;
          state_next = NEXT;
        end else if (bus.dec_done) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        timer_run = 1'b1;
        if (bus.dec_done) begin
          wr_en      = 1'b1;
          wr_digit   = bus.dec_digit[3:0];
          wr_vis     = bus.dec_set | idx_zero | (BLANK_LEADING == 0);
          state_next = NEXT;
        end else if (timeout_hit) begin
          wr_en      = 1'b1;
          wr_vis     = idx_zero;
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_next = SWAP;
        end else begin
          idx_inc    = 1'b1;
          state_next = SETPOS;
        end
      end
      SWAP: begin
        swap       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: scan bookkeeping, digit banks and registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx          <= '0;
      timer        <= '0;
      pending      <= 1'b0;
      busy_q       <= 1'b0;
      number_q     <= '0;
      position_q   <= 4'd0;
      rd_digit_q   <= 4'd0;
      rd_visible_q <= 1'b0;
      // NOTE: the banks are a handful of flops, not RAM, so they are reset
      // to a displayable "0" and a reset mid-scan never exposes partial data.
      for (int i = 0; i < NDIGITS; i++) begin
        shadow[i] <= 4'd0;
        disp[i]   <= 4'd0;
      end
      shadow_vis <= NDIGITS'(1);
      disp_vis   <= NDIGITS'(1);
    end else begin
      // Requests during a scan (including the swap cycle) collapse into one.
      if (bus.score_update && (state != IDLE)) pending <= 1'b1;
      else if (start)                          pending <= 1'b0;

      if (start) begin
        number_q <= bus.score;
        idx      <= '0;
        busy_q   <= 1'b1;
      end
      if (set_pos) begin
        position_q <= 4'(idx);
        timer      <= '0;
      end
      if (timer_run) timer <= timer + 1'b1;
      if (wr_en) begin
        shadow[idx]     <= wr_digit;
        shadow_vis[idx] <= wr_vis;
      end
      if (idx_inc) idx <= idx + 1'b1;
      if (swap) begin
        disp     <= shadow;
        disp_vis <= shadow_vis;
        busy_q   <= 1'b0;
      end

      if (int'(bus.rd_sel) < NDIGITS) begin
        rd_digit_q   <= disp[bus.rd_sel];
        rd_visible_q <= disp_vis[bus.rd_sel];
      end else begin
        rd_digit_q   <= 4'd0;
        rd_visible_q <= 1'b0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.scan_done    = swap;
  assign bus.dec_number   = number_q;
  assign bus.dec_position = position_q;
  assign bus.rd_digit     = rd_digit_q;
  assign bus.rd_visible   = rd_visible_q;
endmodule

// File: tb/tb_score_digit_scanner.sv
// Bench for score_digit_scanner: a free-running converter model with stale
// first results, a scoreboard of expected banks pushed at each request, and
// a second instance with leading-zero blanking disabled sharing the stimulus.
module tb_score_digit_scanner;
  localparam int ND  = 6;
  localparam int W   = 20;
  localparam int TO  = 64;
  localparam int LAT = 4;

  typedef struct {
    logic [3:0]    d [ND];
    logic [ND-1:0] v;
  } bank_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  score_digit_scanner_if #(.WIDTH(W)) bus ();
  score_digit_scanner_if #(.WIDTH(W)) bus2 ();

  score_digit_scanner #(.NDIGITS(ND), .WIDTH(W), .BLANK_LEADING(1), .TIMEOUT(TO))
    dut (.clk(clk), .reset(reset), .bus(bus));
  score_digit_scanner #(.NDIGITS(ND), .WIDTH(W), .BLANK_LEADING(0), .TIMEOUT(TO))
    dut_all (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.score        = bus.score;
  assign bus2.score_update = bus.score_update;
  assign bus2.dec_done     = bus.dec_done;
  assign bus2.dec_set      = bus.dec_set;
  assign bus2.dec_digit    = bus.dec_digit;
  assign bus2.rd_sel       = bus.rd_sel;

  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  bank_t sb [$];
  bank_t shown;

  function automatic int unsigned p10(input int k);
    int unsigned r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic bank_t model(input int unsigned s, input bit blank);
    bank_t b;
    for (int i = 0; i < ND; i++) begin
      b.d[i] = 4'((s / p10(i)) % 10);
      b.v[i] = (i == 0) || !blank || (s >= p10(i));
    end
    return b;
  endfunction

  // Converter model: latches its inputs at the start of each conversion and
  // reports LAT cycles later, so the first result after a change is stale.
  bit               conv_en = 1'b1;
  int               conv_cnt = 0;
  logic [W-1:0]     c_num;
  logic [3:0]       c_pos;
  always @(negedge clk) begin
    bus.dec_done  = 1'b0;
    bus.dec_set   = 1'b0;
    bus.dec_digit = 5'h1f;
    if (!conv_en) begin
      conv_cnt = 0;
    end else begin
      if (conv_cnt == 0) begin
        c_num = bus.dec_number;
        c_pos = bus.dec_position;
      end
      if (conv_cnt == LAT - 1) begin
        bus.dec_done  = 1'b1;
        bus.dec_digit = {1'b1, 4'((int'(c_num) / p10(int'(c_pos))) % 10)};
        bus.dec_set   = (c_pos == 4'd0) || (int'(c_num) >= p10(int'(c_pos)));
        conv_cnt = 0;
      end else begin
        conv_cnt++;
      end
    end
  end

  always @(negedge clk) if (bus.scan_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input int unsigned s);
    @(negedge clk);
    bus.score = W'(s);
    bus.score_update = 1'b1;
    @(negedge clk);
    bus.score_update = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    bus.score_update = 1'b1;
    @(negedge clk);
    bus.score_update = 1'b0;
  endtask

  task automatic sweep(input string tag, input bank_t exp, input bit chk2);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ed;
      logic       ev;
      ed = 4'd0;
      ev = 1'b0;
      if (i < ND) begin
        ed = exp.d[i];
        ev = exp.v[i];
      end
      @(negedge clk);
      bus.rd_sel = 3'(i);
      @(posedge clk);
      #1;
      check($sformatf("%s_d%0d", tag, i), bus.rd_digit, ed);
      check($sformatf("%s_v%0d", tag, i), bus.rd_visible, ev);
      if (chk2) begin
        check($sformatf("%s_all_d%0d", tag, i), bus2.rd_digit, ed);
        check($sformatf("%s_all_v%0d", tag, i), bus2.rd_visible, i < ND);
      end
    end
  endtask

  // Waits for scan_done, checks the swap-cycle read returns the old bank and
  // the following read the new one, then sweeps the popped expected bank.
  task automatic scan_and_check(input string tag, input int budget, input int probe,
                                input bit chk2, output int cyc);
    bank_t exp;
    bit    seen;
    seen = 1'b0;
    cyc  = 0;
    exp  = model(0, 1'b1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
    end else begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    bus.rd_sel = 3'(probe);
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      seen = (bus.scan_done === 1'b1);
    end
    check({tag, "_done"}, seen, 1);
    if (seen) begin
      @(posedge clk);
      #1;
      check({tag, "_swap_old_d"}, bus.rd_digit, shown.d[probe]);
      check({tag, "_swap_old_v"}, bus.rd_visible, shown.v[probe]);
      @(posedge clk);
      #1;
      check({tag, "_swap_new_d"}, bus.rd_digit, exp.d[probe]);
      check({tag, "_swap_new_v"}, bus.rd_visible, exp.v[probe]);
    end
    sweep(tag, exp, chk2);
    shown = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc;
    int  base;
    bit  reached;
    bus.score        = '0;
    bus.score_update = 1'b0;
    bus.rd_sel       = 3'd0;
    reset            = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", bus.busy, 0);
    check("rst_scan_done", bus.scan_done, 0);
    check("rst_dec_number", bus.dec_number, 0);
    check("rst_dec_position", bus.dec_position, 0);
    check("rst_rd_digit", bus.rd_digit, 0);
    check("rst_rd_visible", bus.rd_visible, 0);
    reset = 1'b1;
    shown = model(0, 1'b1);
    sweep("rst_bank", shown, 1'b0);

    // 12345 through the converter.
    base = done_cnt;
    start_scan(12345);
    sb.push_back(model(12345, 1'b1));
    check("t1_busy", bus.busy, 1);
    scan_and_check("t1", 300, 4, 1'b0, cyc);
    check("t1_one_done", done_cnt - base, 1);
    check("t1_idle", bus.busy, 0);

    // Read latency: output still shows the previous selection until the edge.
    @(negedge clk);
    bus.rd_sel = 3'd7;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.rd_sel = 3'd1;
    check("t6_lat_hold", bus.rd_digit, 0);
    @(posedge clk);
    #1;
    check("t6_lat_new", bus.rd_digit, 4);

    // Score 0, both blanking modes.
    start_scan(0);
    sb.push_back(model(0, 1'b1));
    scan_and_check("t2", 300, 2, 1'b1, cyc);

    // Converter silent: every digit times out.
    conv_en = 1'b0;
    start_scan(4321);
    sb.push_back(model(0, 1'b1));
    scan_and_check("t4", 1000, 0, 1'b0, cyc);
    check("t4_len", cyc >= ND * TO, 1);
    conv_en = 1'b1;

    // Overlapping requests collapse into one rescan with the newest score.
    base = done_cnt;
    start_scan(999);
    sb.push_back(model(999, 1'b1));
    repeat (5) @(negedge clk);
    check("t3_busy", bus.busy, 1);
    bus.score = W'(100);
    pulse();
    repeat (2) @(negedge clk);
    pulse();
    pulse();
    sb.push_back(model(100, 1'b1));
    scan_and_check("t3a", 300, 2, 1'b0, cyc);
    bus.score = W'(777);
    check("t3_rescan_busy", bus.busy, 1);
    check("t3_rescan_number", bus.dec_number, 100);
    scan_and_check("t3b", 300, 2, 1'b0, cyc);
    repeat (300) @(negedge clk);
    check("t3_two_done", done_cnt - base, 2);
    check("t3_idle", bus.busy, 0);

    // Reset during digit 3 of a scan.
    base = done_cnt;
    start_scan(654321);
    sb.push_back(model(654321, 1'b1));
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clk);
      reached = (bus.dec_position == 4'd3);
    end
    check("t5_reached_idx3", reached, 1);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_number", bus.dec_number, 0);
    check("t5_rst_position", bus.dec_position, 0);
    check("t5_rst_rd_visible", bus.rd_visible, 0);
    reset = 1'b1;
    sb.delete();
    repeat (200) @(negedge clk);
    check("t5_no_done", done_cnt - base, 0);
    check("t5_idle", bus.busy, 0);
    sweep("t5_bank", model(0, 1'b1), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
